// File: rtl/ioctl_download_master.sv
// Initiator for the emu ioctl download port: replays a valid/ready byte stream
// as a framed download with setup, inter-write gap and hold timing.
module ioctl_download_master #(
   parameter int ADDR_W    = 25,
   parameter int SETUP_CYC = 4,
   parameter int GAP_CYC   = 2,
   parameter int HOLD_CYC  = 4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        index,
   input  logic [ADDR_W-1:0] length,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              ioctl_download,
   output logic              ioctl_wr,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout,
   output logic [7:0]        ioctl_index,
   input  logic              ioctl_wait,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, FETCH, WRITE, GAP, HOLD} state_t;

   state_t            state;
   logic [ADDR_W-1:0] remaining;
   logic [CNT_W-1:0]  cnt;

   // Single registered FSM; ioctl_wr and done default low so they only pulse.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         remaining      <= '0;
         cnt            <= '0;
         s_ready        <= 1'b0;
         ioctl_download <= 1'b0;
         ioctl_wr       <= 1'b0;
         ioctl_addr     <= '0;
         ioctl_dout     <= '0;
         ioctl_index    <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         ioctl_wr <= 1'b0;
         done     <= 1'b0;
         if (abort && state != IDLE) begin
            state          <= IDLE;
            remaining      <= '0;
            cnt            <= '0;
            s_ready        <= 1'b0;
            ioctl_download <= 1'b0;
            busy           <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     ioctl_index    <= index;
                     remaining      <= length;
                     ioctl_addr     <= '0;
                     cnt            <= '0;
                     ioctl_download <= 1'b1;
                     busy           <= 1'b1;
                     state          <= SETUP;
                  end
               end
               SETUP: begin
                  if (cnt == SETUP_LAST) begin
                     cnt <= '0;
                     if (remaining == '0) begin
                        state <= HOLD;
                     end else begin
                        state   <= FETCH;
                        s_ready <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FETCH: begin
                  if (s_valid && s_ready) begin
                     ioctl_dout <= s_data;
                     s_ready    <= 1'b0;
                     state      <= WRITE;
                  end
               end
               WRITE: begin
                  if (!ioctl_wait) begin
                     ioctl_wr  <= 1'b1;
                     remaining <= remaining - 1'b1;
                     cnt       <= '0;
                     state     <= GAP;
                  end
               end
               GAP: begin
                  // Address only advances when another byte follows, so it ends on length-1.
                  if (cnt == '0 && remaining != '0)
                     ioctl_addr <= ioctl_addr + 1'b1;
                  if (cnt == GAP_LAST) begin
                     cnt <= '0;
                     if (remaining != '0) begin
                        state   <= FETCH;
                        s_ready <= 1'b1;
                     end else begin
                        state <= HOLD;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (cnt == HOLD_LAST) begin
                     cnt            <= '0;
                     ioctl_download <= 1'b0;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ioctl_download_master.sv
// Randomized and directed bench for ioctl_download_master, checked against a
// transaction-level model of the expected write list and frame timing.
module tb_ioctl_download_master;

   localparam int ADDR_W    = 25;
   localparam int SETUP_CYC = 4;
   localparam int GAP_CYC   = 2;
   localparam int HOLD_CYC  = 4;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        index = '0;
   logic [ADDR_W-1:0] length = '0;
   logic              abort = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data = '0;
   logic              s_ready;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait = 1'b0;
   logic              busy;
   logic              done;

   ioctl_download_master #(
      .ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .index(index),
      .length(length), .abort(abort), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
      .ioctl_wait(ioctl_wait), .busy(busy), .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int startCyc = 0;
   int stallFrom = -1;
   int stallTo = -1;
   bit validRandom = 0;
   bit waitRandom = 0;
   byte unsigned srcQ[$];
   byte unsigned expQ[$];
   int wrCycQ[$];
   int wrAddrQ[$];
   int wrDataQ[$];
   int doneCycQ[$];
   int dlCount = 0;
   int protoErrs = 0;
   bit prevWr = 0;

   initial forever begin
      @(posedge clk_sys);
      cyc++;
   end

   // Source feeds bytes from srcQ; a byte leaves the queue only on a handshake.
   initial forever begin
      @(posedge clk_sys);
      if (s_valid && s_ready && srcQ.size() > 0) void'(srcQ.pop_front());
      @(negedge clk_sys);
      if (srcQ.size() > 0 && (!validRandom || $urandom_range(0, 2) != 0)) begin
         s_valid = 1'b1;
         s_data  = srcQ[0];
      end else begin
         s_valid = 1'b0;
      end
      ioctl_wait = waitRandom ? ($urandom_range(0, 3) == 0) : (cyc >= stallFrom && cyc < stallTo);
   end

   // Sink-side observer: logs every write and done pulse with its cycle number.
   initial forever begin
      @(negedge clk_sys);
      if (ioctl_download) dlCount++;
      if (ioctl_wr) begin
         wrCycQ.push_back(cyc);
         wrAddrQ.push_back(int'(ioctl_addr));
         wrDataQ.push_back(int'(ioctl_dout));
         if (!ioctl_download || prevWr) protoErrs++;
      end
      if (done) begin
         doneCycQ.push_back(cyc);
         if (ioctl_download || busy) protoErrs++;
      end
      prevWr = ioctl_wr;
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearLogs();
      wrCycQ.delete();
      wrAddrQ.delete();
      wrDataQ.delete();
      doneCycQ.delete();
      dlCount = 0;
      protoErrs = 0;
   endtask

   task automatic loadBytes(input int n);
      expQ.delete();
      for (int i = 0; i < n; i++) expQ.push_back(byte'($urandom_range(0, 255)));
      srcQ = expQ;
   endtask

   task automatic applyStimulus(input logic [7:0] idx, input logic [ADDR_W-1:0] len, input logic withAbort);
      @(negedge clk_sys);
      #1;
      clearLogs();
      start    = 1'b1;
      abort    = withAbort;
      index    = idx;
      length   = len;
      startCyc = cyc;
      @(negedge clk_sys);
      #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      for (int i = 0; i < budget && doneCycQ.size() == 0; i++) @(negedge clk_sys);
      repeat (3) @(negedge clk_sys);
      #1;
      checkOutput({tag, "_done_count"}, doneCycQ.size(), 1);
   endtask

   task automatic checkWrites(input string tag, input int n);
      checkOutput({tag, "_wr_count"}, wrCycQ.size(), n);
      for (int k = 0; k < n && k < wrCycQ.size(); k++) begin
         checkOutput($sformatf("%s_addr%0d", tag, k), wrAddrQ[k], k);
         checkOutput($sformatf("%s_data%0d", tag, k), wrDataQ[k], expQ[k]);
      end
   endtask

   task automatic waitWrites(input int n, input int budget);
      for (int i = 0; i < budget && wrCycQ.size() < n; i++) begin
         @(negedge clk_sys);
         #1;
      end
      checkOutput($sformatf("reach_wr%0d", n), wrCycQ.size() >= n, 1);
   endtask

   function automatic longint outVec();
      return longint'({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, s_ready, busy, done});
   endfunction

   initial begin
      int expFirst;
      int expDone;
      int spacingBad;
      int n;

      repeat (3) @(negedge clk_sys);
      checkOutput("reset_outputs", outVec(), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Plain 4-byte download with fixed bytes and exact timing.
      expQ = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      srcQ = expQ;
      applyStimulus(8'h02, 4, 1'b0);
      waitDone("basic", 200);
      checkWrites("basic", 4);
      expFirst = startCyc + 1 + SETUP_CYC + 2;
      expDone  = expFirst + 3 * (GAP_CYC + 2) + HOLD_CYC + 2;
      if (wrCycQ.size() == 4) begin
         checkOutput("basic_first_cyc", wrCycQ[0], expFirst);
         for (int k = 1; k < 4; k++)
            checkOutput($sformatf("basic_period%0d", k), wrCycQ[k] - wrCycQ[k-1], GAP_CYC + 2);
      end
      if (doneCycQ.size() > 0) checkOutput("basic_done_cyc", doneCycQ[0], expDone);
      checkOutput("basic_dl_cycles", dlCount, expDone - startCyc - 1);
      checkOutput("basic_final", {ioctl_index, ioctl_addr, ioctl_dout, busy, ioctl_download},
                  {8'h02, ADDR_W'(3), 8'hA3, 2'b00});
      checkOutput("basic_proto", protoErrs, 0);

      // Sink stall of 10 cycles starting at the second write's WRITE cycle.
      loadBytes(3);
      stallFrom = cyc + 1 + 1 + 1 + SETUP_CYC + 2 + GAP_CYC + 1;
      applyStimulus(8'h11, 3, 1'b0);
      stallFrom = startCyc + 1 + SETUP_CYC + 2 + GAP_CYC + 1;
      stallTo   = stallFrom + 10;
      while (cyc < stallFrom + 5) @(negedge clk_sys);
      #1;
      checkOutput("stall_hold", {ioctl_addr, ioctl_dout, ioctl_wr}, {ADDR_W'(1), expQ[1], 1'b0});
      waitDone("stall", 300);
      stallFrom = -1;
      stallTo   = -1;
      checkWrites("stall", 3);
      if (wrCycQ.size() == 3) begin
         checkOutput("stall_delay", wrCycQ[1] - wrCycQ[0], GAP_CYC + 2 + 10);
         checkOutput("stall_after", wrCycQ[2] - wrCycQ[1], GAP_CYC + 2);
      end

      // Zero-length download, with abort on the same cycle as start (start wins).
      srcQ.delete();
      applyStimulus(8'h07, 0, 1'b1);
      waitDone("len0", 100);
      checkOutput("len0_wr_count", wrCycQ.size(), 0);
      checkOutput("len0_dl_cycles", dlCount, SETUP_CYC + HOLD_CYC);
      if (doneCycQ.size() > 0) checkOutput("len0_done_cyc", doneCycQ[0], startCyc + 1 + SETUP_CYC + HOLD_CYC);
      checkOutput("len0_addr", ioctl_addr, 0);

      // Abort after the third write; nothing more may happen.
      loadBytes(8);
      applyStimulus(8'h21, 8, 1'b0);
      waitWrites(3, 200);
      abort = 1'b1;
      @(negedge clk_sys);
      #1;
      abort = 1'b0;
      checkOutput("abort_next", {ioctl_download, ioctl_wr, s_ready, busy}, 4'b0000);
      srcQ.delete();
      repeat (30) @(negedge clk_sys);
      #1;
      checkOutput("abort_wr_count", wrCycQ.size(), 3);
      checkOutput("abort_no_done", doneCycQ.size(), 0);
      loadBytes(2);
      applyStimulus(8'h22, 2, 1'b0);
      waitDone("restart", 200);
      checkWrites("restart", 2);

      // Second start while busy must be ignored.
      loadBytes(5);
      applyStimulus(8'h33, 5, 1'b0);
      waitWrites(1, 200);
      start  = 1'b1;
      index  = 8'h05;
      length = 2;
      @(negedge clk_sys);
      #1;
      start = 1'b0;
      waitDone("busystart", 300);
      checkWrites("busystart", 5);
      checkOutput("busystart_index", ioctl_index, 8'h33);

      // Asynchronous reset in the middle of the first WRITE cycle.
      loadBytes(4);
      applyStimulus(8'h5A, 4, 1'b0);
      for (int i = 0; i < 50 && cyc < startCyc + 1 + SETUP_CYC + 1; i++) @(negedge clk_sys);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset", outVec(), 0);
      srcQ.delete();
      clearLogs();
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);
      #1;
      checkOutput("post_reset_wr", wrCycQ.size(), 0);
      checkOutput("post_reset_idle", {ioctl_download, busy, s_ready}, 3'b000);

      // Random lengths, bytes, source gaps and sink stalls.
      validRandom = 1;
      waitRandom  = 1;
      for (int t = 0; t < 6; t++) begin
         logic [7:0] idx;
         n   = $urandom_range(1, 10);
         idx = 8'($urandom_range(0, 255));
         loadBytes(n);
         applyStimulus(idx, ADDR_W'(n), 1'b0);
         waitDone($sformatf("rnd%0d", t), 1500);
         checkWrites($sformatf("rnd%0d", t), n);
         spacingBad = 0;
         for (int k = 1; k < wrCycQ.size(); k++)
            if (wrCycQ[k] - wrCycQ[k-1] < GAP_CYC + 2) spacingBad++;
         if (wrCycQ.size() > 0 && wrCycQ[0] < startCyc + 1 + SETUP_CYC + 2) spacingBad++;
         checkOutput($sformatf("rnd%0d_spacing", t), spacingBad, 0);
         if (wrCycQ.size() > 0 && doneCycQ.size() > 0)
            checkOutput($sformatf("rnd%0d_done_cyc", t), doneCycQ[0], wrCycQ[wrCycQ.size()-1] + HOLD_CYC + 2);
         checkOutput($sformatf("rnd%0d_final", t), {ioctl_index, ioctl_addr}, {idx, ADDR_W'(n - 1)});
         checkOutput($sformatf("rnd%0d_proto", t), protoErrs, 0);
      end
      validRandom = 0;
      waitRandom  = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
